iob_uart_bridge: RTL and testbench

IOB_UART_BRIDGE -- requirements
Module: iob_uart_bridge

---
 rtl/iob_uart_bridge_pkg.sv | 28 ++
 rtl/iob_uart_bridge_fifo.sv | 42 ++++
 rtl/iob_uart_bridge.sv | 135 +++++++++++++
 tb/tb_iob_uart_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_uart_bridge_pkg.sv
// iob_uart_bridge_pkg: UART register map, FSM encoding and byte-lane helpers for the bridge
package iob_uart_bridge_pkg;
  localparam int IOB_UART_SWREG_ADDR_W = 4;
  localparam logic [3:0] IOB_UART_SOFTRESET_ADDR = 4'd0;
  localparam logic [3:0] IOB_UART_DIV_ADDR       = 4'd2;
  localparam logic [3:0] IOB_UART_TXDATA_ADDR    = 4'd4;
  localparam logic [3:0] IOB_UART_TXEN_ADDR      = 4'd5;
  localparam logic [3:0] IOB_UART_TXREADY_ADDR   = 4'd6;
  localparam logic [3:0] IOB_UART_RXDATA_ADDR    = 4'd8;
  localparam logic [3:0] IOB_UART_RXEN_ADDR      = 4'd9;
  localparam logic [3:0] IOB_UART_RXREADY_ADDR   = 4'd10;
  localparam int IOB_UART_SOFTRESET_W = 1;
  localparam int IOB_UART_DIV_W       = 16;
  localparam int IOB_UART_TXDATA_W    = 8;
  localparam int IOB_UART_TXEN_W      = 1;
  localparam int IOB_UART_TXREADY_W   = 1;
  localparam int IOB_UART_RXDATA_W    = 8;
  localparam int IOB_UART_RXEN_W      = 1;
  localparam int IOB_UART_RXREADY_W   = 1;
  localparam int INIT_STEPS = 5;
  localparam logic [1:0] STRB_8  = 2'b01;
  localparam logic [1:0] STRB_16 = 2'b11;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_TXPOLL, ST_TXWR, ST_RXPOLL, ST_RXRD} state_e;
  // Unshifted strobe pattern for a register of the given bit width
  function automatic logic [1:0] strb_base(input int w);
    return w == 16 ? STRB_16 : STRB_8;
  endfunction
endpackage

// File: rtl/iob_uart_bridge_fifo.sv
// iob_uart_bridge_fifo: small TX byte FIFO with registered full/empty flags
module iob_uart_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic full_q, empty_q;
  assign wptr_d = wptr_q + (AW+1)'(push_i && !full_q);
  assign rptr_d = rptr_q + (AW+1)'(pop_i && !empty_q);
  assign data_o = mem_q[rptr_q[AW-1:0]];
  assign full_o = full_q;
  assign empty_o = empty_q;
  // Pointers carry an extra wrap bit; flags are computed from next pointers so they come out registered
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full_q <= (wptr_d ^ rptr_d) == {1'b1, {AW{1'b0}}};
      empty_q <= wptr_d == rptr_d;
    end
  end
  // Storage needs no reset; only pointers define validity
  always_ff @(posedge clk_i) begin
    if (push_i && !full_q) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/iob_uart_bridge.sv
// iob_uart_bridge: bridges TX/RX byte streams to a UART register block over a single-outstanding IOb master
module iob_uart_bridge import iob_uart_bridge_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = IOB_UART_SWREG_ADDR_W,
  parameter logic [15:0] DIV_VAL = 16'd10,
  parameter int TXF_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic [7:0]          tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                init_done_o
);
  localparam int STRB_W = DATA_W / 8;
  state_e state_q;
  logic [2:0] step_q;
  logic prio_q, busy_q, avalid_q, rx_valid_q, init_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [7:0] rx_data_q, txf_head, rd_byte;
  logic txf_full, txf_empty, pop, done, req_wr;
  logic [3:0] req_addr;
  logic [15:0] req_val;
  int req_w;
  iob_uart_bridge_fifo #(.DEPTH(TXF_DEPTH), .W(8)) u_txf (
    .clk_i(clk_i),
    .arst_n_i(arst_n_i),
    .push_i(tx_valid_i),
    .data_i(tx_data_i),
    .pop_i(pop),
    .data_o(txf_head),
    .full_o(txf_full),
    .empty_o(txf_empty)
  );
  assign tx_ready_o = !txf_full;
  assign rx_data_o = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign init_done_o = init_done_q;
  assign iob_avalid_o = avalid_q;
  assign iob_addr_o = addr_q;
  assign iob_wdata_o = wdata_q;
  assign iob_wstrb_o = wstrb_q;
  assign rd_byte = 8'(iob_rdata_i >> {addr_q[1:0], 3'b000});
  assign pop = state_q == ST_TXWR && avalid_q && iob_ready_i;
  assign done = busy_q && (avalid_q ? iob_ready_i && (req_wr || iob_rvalid_i) : iob_rvalid_i);
  // Register access each state issues; held constant while the state is busy
  always_comb begin
    req_addr = IOB_UART_TXREADY_ADDR;
    req_w = IOB_UART_TXREADY_W;
    req_val = '0;
    req_wr = 1'b0;
    case (state_q)
      ST_INIT: begin
        req_wr = 1'b1;
        case (step_q)
          3'd0: begin req_addr = IOB_UART_SOFTRESET_ADDR; req_w = IOB_UART_SOFTRESET_W; req_val = 16'd1; end
          3'd1: begin req_addr = IOB_UART_SOFTRESET_ADDR; req_w = IOB_UART_SOFTRESET_W; end
          3'd2: begin req_addr = IOB_UART_DIV_ADDR; req_w = IOB_UART_DIV_W; req_val = DIV_VAL; end
          3'd3: begin req_addr = IOB_UART_TXEN_ADDR; req_w = IOB_UART_TXEN_W; req_val = 16'd1; end
          default: begin req_addr = IOB_UART_RXEN_ADDR; req_w = IOB_UART_RXEN_W; req_val = 16'd1; end
        endcase
      end
      ST_TXWR: begin req_wr = 1'b1; req_addr = IOB_UART_TXDATA_ADDR; req_w = IOB_UART_TXDATA_W; req_val = {8'h00, txf_head}; end
      ST_RXPOLL: begin req_addr = IOB_UART_RXREADY_ADDR; req_w = IOB_UART_RXREADY_W; end
      ST_RXRD: begin req_addr = IOB_UART_RXDATA_ADDR; req_w = IOB_UART_RXDATA_W; end
      default: ;
    endcase
  end
  // Control FSM: IDLE arbitrates, every other state issues one access, waits for ready/rvalid, then moves on
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_INIT;
      step_q <= '0;
      prio_q <= 1'b0;
      busy_q <= 1'b0;
      avalid_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (!txf_empty && (rx_valid_q || !prio_q)) begin
          state_q <= ST_TXPOLL;
          prio_q <= 1'b1;
        end else if (!rx_valid_q) begin
          state_q <= ST_RXPOLL;
          prio_q <= 1'b0;
        end
      end else if (!busy_q) begin
        busy_q <= 1'b1;
        avalid_q <= 1'b1;
        addr_q <= ADDR_W'(req_addr);
        wdata_q <= DATA_W'(req_val) << {req_addr[1:0], 3'b000};
        wstrb_q <= STRB_W'(strb_base(req_w)) << req_addr[1:0];
      end else begin
        if (iob_ready_i) avalid_q <= 1'b0;
        if (done) begin
          busy_q <= 1'b0;
          case (state_q)
            ST_INIT: begin
              if (step_q == 3'(INIT_STEPS - 1)) begin
                state_q <= ST_IDLE;
                init_done_q <= 1'b1;
              end else step_q <= step_q + 3'd1;
            end
            ST_TXPOLL: state_q <= rd_byte[0] ? ST_TXWR : ST_IDLE;
            ST_RXPOLL: state_q <= rd_byte[0] ? ST_RXRD : ST_IDLE;
            ST_RXRD: begin
              rx_data_q <= rd_byte;
              rx_valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_iob_uart_bridge.sv
// tb_iob_uart_bridge: scoreboard bench with a behavioural UART register slave for iob_uart_bridge
module tb_iob_uart_bridge;
  typedef struct packed {logic [3:0] a; logic [3:0] s; logic [31:0] d;} wr_t;
  logic clk = 0, arst_n = 0;
  logic [7:0] tx_data = 0, rx_data;
  logic tx_valid = 0, tx_ready, rx_valid, rx_ready = 0;
  logic avalid, init_done;
  logic [3:0] addr, wstrb;
  logic [31:0] wdata, iob_rdata = 0;
  logic iob_ready = 0, iob_rvalid = 0;
  int tests = 0, fails = 0;
  int ready_dly = 0, rvalid_dly = 0, txr_def = 1, rxr_def = 0;
  bit rnd = 0, hold_txd = 0;
  int txr_q[$];
  logic [7:0] rxd_q[$], exp_tx[$], exp_rx[$];
  wr_t exp_init[$];
  int marks[$];
  int rxpolls = 0;
  always #5 clk = ~clk;
  iob_uart_bridge #(.DATA_W(32), .ADDR_W(4), .DIV_VAL(16'd10), .TXF_DEPTH(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .iob_avalid_o(avalid), .iob_addr_o(addr), .iob_wdata_o(wdata), .iob_wstrb_o(wstrb),
    .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata),
    .init_done_o(init_done)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Expected bus write from the lane rules: strobe 1 or 3 shifted by addr[1:0], data in that lane
  function automatic wr_t mk(input logic [3:0] a, input int v, input bit w16);
    wr_t r;
    r.a = a;
    r.d = 32'(v) << (8 * int'(a[1:0]));
    r.s = (w16 ? 4'd3 : 4'd1) << a[1:0];
    return r;
  endfunction
  task automatic push_init();
    exp_init.delete();
    exp_init.push_back(mk(4'd0, 1, 0));
    exp_init.push_back(mk(4'd0, 0, 0));
    exp_init.push_back(mk(4'd2, 10, 1));
    exp_init.push_back(mk(4'd5, 1, 0));
    exp_init.push_back(mk(4'd9, 1, 0));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    tx_valid = 1;
    tx_data = b;
    while (!tx_ready && n < 500) begin step(); n++; end
    chk("tx_accept", tx_ready, 1);
    if (tx_ready) exp_tx.push_back(b);
    step();
    tx_valid = 0;
  endtask
  // Register slave plus protocol and RX-stream monitor, all evaluated mid-cycle
  always @(negedge clk) begin : bus
    static int wcnt = 0, rvcnt = 0, v;
    static logic [31:0] resp, pend;
    static bit rd, p_av = 0, p_rxv = 0, p_rxhs = 0, init_fin = 0, last_r = 0;
    static logic [3:0] p_a, p_s, last_a = 4'hF;
    static logic [31:0] p_d;
    static logic [7:0] p_rxd;
    static wr_t w;
    if (!arst_n) begin
      wcnt = 0; rvcnt = 0; iob_ready = 0; iob_rvalid = 0;
      p_av = 0; p_rxv = 0; p_rxhs = 0; init_fin = 0; last_a = 4'hF; last_r = 0;
    end else begin
      if (p_av && !iob_ready) chk("req_hold", {avalid, addr, wstrb, wdata}, {1'b1, p_a, p_s, p_d});
      if (p_av && iob_ready) chk("avalid_gap", avalid, 0);
      if (rvcnt > 0) chk("rvalid_wait", avalid, 0);
      if (init_fin) begin chk("init_done_edge", init_done, 1); init_fin = 0; end
      if (p_rxhs) chk("rx_clear", rx_valid, 0);
      else if (p_rxv) chk("rx_hold", {rx_valid, rx_data}, {1'b1, p_rxd});
      if (rx_valid && rx_ready) chk("rx_data", rx_data, exp_rx.size() != 0 ? {1'b0, exp_rx.pop_front()} : 9'h100);
      iob_ready = 0;
      iob_rvalid = 0;
      if (rvcnt > 0) begin
        rvcnt--;
        if (rvcnt == 0) begin iob_rvalid = 1; iob_rdata = pend; end
      end else if (avalid && !(hold_txd && addr == 4'd4)) begin
        if (wcnt < ready_dly) wcnt++;
        else begin
          wcnt = 0;
          iob_ready = 1;
          rd = 1;
          resp = 0;
          case (addr)
            4'd6: resp = txr_q.size() != 0 ? 32'(txr_q.pop_front()) : (rnd ? $urandom_range(0, 1) : 32'(txr_def));
            4'd10: begin
              resp = rnd ? $urandom_range(0, 1) : 32'(rxr_def);
              rxpolls++;
              chk("rxpoll_while_valid", rx_valid, 0);
            end
            4'd8: begin
              resp = rxd_q.size() != 0 ? 32'(rxd_q.pop_front()) : $urandom_range(0, 255);
              exp_rx.push_back(resp[7:0]);
              chk("rxdata_after_poll", {last_a, last_r}, {4'd10, 1'b1});
            end
            default: rd = 0;
          endcase
          if (rd) begin
            pend = resp << {addr[1:0], 3'b000};
            if (rvalid_dly == 0) begin iob_rvalid = 1; iob_rdata = pend; end
            else rvcnt = rvalid_dly;
          end else if (exp_init.size() != 0) begin
            w = exp_init.pop_front();
            chk("init_wr", {addr, wstrb, wdata}, w);
            if (exp_init.size() == 0) begin chk("init_done_early", init_done, 0); init_fin = 1; end
          end else if (addr == 4'd4) begin
            v = exp_tx.size() != 0 ? int'(exp_tx.pop_front()) : 256;
            w = mk(4'd4, v, 0);
            chk("txdata_wr", {wstrb, wdata}, {w.s, w.d});
            chk("txdata_after_poll", {last_a, last_r}, {4'd6, 1'b1});
            chk("txdata_after_init", init_done, 1);
            marks.push_back(rxpolls);
          end else chk("unexpected_wr_addr", addr, 4'd4);
          last_a = addr;
          last_r = rd & resp[0];
          if (rnd) begin ready_dly = $urandom_range(0, 3); rvalid_dly = $urandom_range(0, 3); end
        end
      end
      p_av = avalid; p_a = addr; p_s = wstrb; p_d = wdata;
      p_rxhs = rx_valid && rx_ready;
      p_rxv = rx_valid && !rx_ready;
      p_rxd = rx_data;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required earlier finish", $time);
    $fatal(1);
  end
  initial begin
    int n, p;
    repeat (3) step();
    chk("rst_iob", {avalid, addr, wstrb, wdata}, 64'd0);
    chk("rst_rx", {rx_valid, rx_data}, 64'd0);
    chk("rst_init_done", init_done, 0);
    chk("rst_tx_ready", tx_ready, 1);
    push_init();
    marks.delete();
    arst_n = 1;
    send(8'h41);
    send(8'h42);
    n = 0;
    while (!init_done && n < 200) begin step(); n++; end
    chk("init_done", init_done, 1);
    chk("init_seq_complete", exp_init.size(), 0);
    n = 0;
    while ((exp_tx.size() != 0 || marks.size() < 2) && n < 500) begin step(); n++; end
    chk("tx_drain", {exp_tx.size(), marks.size()}, {32'd0, 32'd2});
    chk("rx_interleave", marks.size() == 2 && marks[1] > marks[0], 1);
    ready_dly = 2;
    txr_q = '{0, 0, 0};
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    chk("tx_full", tx_ready, 0);
    send(8'h14);
    n = 0;
    while (exp_tx.size() != 0 && n < 1000) begin step(); n++; end
    chk("bp_drain", exp_tx.size(), 0);
    chk("bp_zero_polls_used", txr_q.size(), 0);
    ready_dly = 0;
    rvalid_dly = 3;
    rxd_q.push_back(8'h5A);
    rxr_def = 1;
    n = 0;
    while (!rx_valid && n < 200) begin step(); n++; end
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data_5a", rx_data, 8'h5A);
    p = rxpolls;
    repeat (20) step();
    chk("no_rx_poll_while_valid", rxpolls, p);
    chk("rx_still_valid", {rx_valid, rx_data}, {1'b1, 8'h5A});
    rx_ready = 1;
    step();
    rx_ready = 0;
    chk("rx_cleared", rx_valid, 0);
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      rx_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) != 0) send(8'($urandom_range(0, 255)));
      else step();
    end
    rnd = 0;
    ready_dly = 0;
    rvalid_dly = 0;
    txr_def = 1;
    rxr_def = 0;
    rx_ready = 1;
    n = 0;
    while ((exp_tx.size() != 0 || exp_rx.size() != 0 || rx_valid) && n < 2000) begin step(); n++; end
    chk("rand_drain", {exp_tx.size(), exp_rx.size()}, 64'd0);
    rx_ready = 0;
    hold_txd = 1;
    send(8'h77);
    n = 0;
    while (!(avalid && addr == 4'd4) && n < 200) begin step(); n++; end
    chk("txwr_pending", {avalid, addr}, {1'b1, 4'd4});
    #2 arst_n = 0;
    #1;
    chk("async_rst_iob", {avalid, addr, wstrb, wdata}, 64'd0);
    chk("async_rst_rx", {rx_valid, rx_data}, 64'd0);
    chk("async_rst_flags", {init_done, tx_ready}, 2'b01);
    exp_tx.delete();
    exp_rx.delete();
    hold_txd = 0;
    step();
    step();
    push_init();
    p = marks.size();
    arst_n = 1;
    n = 0;
    while (!init_done && n < 200) begin step(); n++; end
    chk("reinit_done", init_done, 1);
    chk("reinit_seq", exp_init.size(), 0);
    repeat (40) step();
    chk("fifo_empty_after_rst", marks.size(), p);
    chk("tx_ready_after_rst", tx_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
